// File: rtl/dac_sample_sequencer.sv
// Paces 12-bit sample codes from a small valid/ready FIFO into the DAC at a programmable rate.
// Optional saturating underrun counter enabled by defining DAC_SEQ_UNDERRUN_CNT_EN.
module dac_sample_sequencer #(
    parameter int          DIV_W      = 16,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [11:0] MIDSCALE   = 12'h800
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic [DIV_W-1:0] div,
    input  logic [11:0]      s_data,
    input  logic             s_valid,
    output logic             s_ready,
    output logic [11:0]      dac_data,
    output logic             dac_en,
    output logic             busy,
    output logic             underrun
`ifdef DAC_SEQ_UNDERRUN_CNT_EN
    ,
    output logic [15:0]      underrun_cnt
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_L = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [AW:0]      occ_q, occ_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [11:0]      mem_q [FIFO_DEPTH];
    logic [11:0]      mem_d [FIFO_DEPTH];
    logic [11:0]      dac_data_q, dac_data_d;
    logic             dac_en_q, dac_en_d;
    logic             underrun_q, underrun_d;
    logic             tick, push, pop, empty;

    always_comb begin
        empty   = (occ_q == '0);
        s_ready = (occ_q != DEPTH_L);
        tick    = (state_q != IDLE) && (cnt_q == '0);
        push    = s_valid && s_ready;
        pop     = tick && !empty;

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = s_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + AW'(1);

        occ_d = occ_q;
        case ({push, pop})
            2'b10:   occ_d = occ_q + (AW+1)'(1);
            2'b01:   occ_d = occ_q - (AW+1)'(1);
            default: occ_d = occ_q;
        endcase

        // The divider is frozen in IDLE and reloaded from div on start or on each tick.
        cnt_d = cnt_q;
        if (state_q == IDLE) begin
            if (start) cnt_d = div;
        end else if (tick) begin
            cnt_d = div;
        end else begin
            cnt_d = cnt_q - DIV_W'(1);
        end

        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (stop)  state_d = DRAIN;
            DRAIN:   if (empty) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // An empty tick in RUN re-strobes the DAC on the held code; in DRAIN it is silent.
        dac_en_d   = tick && (pop || (state_q == RUN));
        underrun_d = tick && empty && (state_q == RUN);
        dac_data_d = pop ? mem_q[rd_ptr_q] : dac_data_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            occ_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            dac_data_q <= MIDSCALE;
            dac_en_q   <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            occ_q      <= occ_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            dac_data_q <= dac_data_d;
            dac_en_q   <= dac_en_d;
            underrun_q <= underrun_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign dac_data = dac_data_q;
    assign dac_en   = dac_en_q;
    assign underrun = underrun_q;
    assign busy     = (state_q != IDLE);

`ifdef DAC_SEQ_UNDERRUN_CNT_EN
    logic [15:0] ucnt_q, ucnt_d;

    always_comb begin
        ucnt_d = ucnt_q;
        if ((state_q == IDLE) && start)
            ucnt_d = '0;
        else if (underrun_d && (ucnt_q != 16'hFFFF))
            ucnt_d = ucnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) ucnt_q <= '0;
        else     ucnt_q <= ucnt_d;
    end

    assign underrun_cnt = ucnt_q;
`endif

endmodule

// File: tb/tb_dac_sample_sequencer.sv
// Directed bench for dac_sample_sequencer: reset, pacing, full FIFO, div=0, drain, mid-run reset.
module tb_dac_sample_sequencer;

    logic        clk = 1'b0;
    logic        rst, start, stop, s_valid;
    logic [15:0] div;
    logic [11:0] s_data;
    logic        s_ready, dac_en, busy, underrun;
    logic [11:0] dac_data;
`ifdef DAC_SEQ_UNDERRUN_CNT_EN
    logic [15:0] underrun_cnt;
`endif

    int total = 0;
    int bad   = 0;

    dac_sample_sequencer dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .stop     (stop),
        .div      (div),
        .s_data   (s_data),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .dac_data (dac_data),
        .dac_en   (dac_en),
        .busy     (busy),
        .underrun (underrun)
`ifdef DAC_SEQ_UNDERRUN_CNT_EN
        ,
        .underrun_cnt (underrun_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic push_code(input logic [11:0] v);
        s_data  = v;
        s_valid = 1'b1;
        step();
        s_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; s_valid = 1'b0; s_data = '0; div = 16'd3;

        // 1: reset state
        step(); step();
        chk("rst_data", dac_data, 12'h800);
        chk("rst_en", dac_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", s_ready, 1);
        chk("rst_ur", underrun, 0);
`ifdef DAC_SEQ_UNDERRUN_CNT_EN
        chk("rst_ucnt", underrun_cnt, 0);
`endif
        rst = 1'b0;

        // 2: prefill 100,200,300, div=3 -> strobes 4,8,12 cycles after start
        push_code(12'd100); push_code(12'd200); push_code(12'd300);
        start = 1'b1; step(); start = 1'b0;
        chk("t2_busy", busy, 1);
        chk("t2_en0", dac_en, 0);
        for (int k = 1; k <= 12; k++) begin
            step();
            chk("t2_en", dac_en, (k % 4 == 0));
            chk("t2_ur", underrun, 0);
            if (k == 4)  chk("t2_d1", dac_data, 12'd100);
            if (k == 8)  chk("t2_d2", dac_data, 12'd200);
            if (k == 12) chk("t2_d3", dac_data, 12'd300);
        end
        stop = 1'b1; step(); stop = 1'b0;
        chk("t2_drain", busy, 1);
        step();
        chk("t2_idle", busy, 0);
        chk("t2_ur_end", underrun, 0);

        // 3: full FIFO, pop frees a slot, held s_valid refills it
        div = 16'd1;
        push_code(12'd10); push_code(12'd11); push_code(12'd12); push_code(12'd13);
        chk("t3_full", s_ready, 0);
        s_data = 12'd14; s_valid = 1'b1;
        start = 1'b1; step(); start = 1'b0;
        chk("t3_full_e0", s_ready, 0);
        step();
        chk("t3_full_e1", s_ready, 0);
        chk("t3_en_e1", dac_en, 0);
        step();
        chk("t3_en_e2", dac_en, 1);
        chk("t3_d_e2", dac_data, 12'd10);
        chk("t3_ready_e2", s_ready, 1);
        step();
        chk("t3_refull", s_ready, 0);
        chk("t3_en_e3", dac_en, 0);
        s_valid = 1'b0;
        for (int k = 4; k <= 10; k++) begin
            step();
            chk("t3_en", dac_en, (k % 2 == 0));
            chk("t3_ur", underrun, 0);
            if (k % 2 == 0) chk("t3_data", dac_data, 32'(11 + (k - 4) / 2));
        end
        stop = 1'b1; step(); stop = 1'b0;
        chk("t3_drain", busy, 1);
        step();
        chk("t3_idle", busy, 0);
        chk("t3_en_idle", dac_en, 0);
        chk("t3_ur_idle", underrun, 0);

        // 5: two codes, stop right after start -> both emitted, then idle
        div = 16'd2;
        push_code(12'd21); push_code(12'd22);
        start = 1'b1; step(); start = 1'b0;
        stop = 1'b1; step(); stop = 1'b0;
        chk("t5_drain", busy, 1);
        for (int k = 2; k <= 6; k++) begin
            step();
            chk("t5_en", dac_en, (k % 3 == 0));
            chk("t5_ur", underrun, 0);
            if (k == 3) chk("t5_d1", dac_data, 12'd21);
            if (k == 6) chk("t5_d2", dac_data, 12'd22);
        end
        step();
        chk("t5_idle", busy, 0);
        chk("t5_en_idle", dac_en, 0);

        // 4: div=0, one code -> strobe every cycle, underruns after the first
        div = 16'd0;
        push_code(12'd7);
        start = 1'b1; step(); start = 1'b0;
        chk("t4_busy", busy, 1);
        chk("t4_en0", dac_en, 0);
        step();
        chk("t4_en1", dac_en, 1);
        chk("t4_d1", dac_data, 12'd7);
        chk("t4_ur1", underrun, 0);
        for (int k = 2; k <= 4; k++) begin
            step();
            chk("t4_en", dac_en, 1);
            chk("t4_d", dac_data, 12'd7);
            chk("t4_ur", underrun, 1);
        end
`ifdef DAC_SEQ_UNDERRUN_CNT_EN
        chk("t4_ucnt", underrun_cnt, 3);
`endif
        rst = 1'b1; step(); rst = 1'b0;
        chk("t4_rst_busy", busy, 0);

        // 6: reset mid-RUN with three queued, then start on an empty FIFO
        div = 16'd5;
        push_code(12'd31); push_code(12'd32); push_code(12'd33);
        start = 1'b1; step(); start = 1'b0;
        step(); step();
        rst = 1'b1; step(); rst = 1'b0;
        chk("t6_busy", busy, 0);
        chk("t6_data", dac_data, 12'h800);
        chk("t6_en", dac_en, 0);
        chk("t6_ready", s_ready, 1);
        div = 16'd1;
        start = 1'b1; step(); start = 1'b0;
        step();
        chk("t6_en1", dac_en, 0);
        step();
        chk("t6_en2", dac_en, 1);
        chk("t6_ur2", underrun, 1);
        chk("t6_d2", dac_data, 12'h800);
`ifdef DAC_SEQ_UNDERRUN_CNT_EN
        chk("t6_ucnt", underrun_cnt, 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
